// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Responder side of the memory-stage load/store interface.
//                Accepts one word request at a time, inserts WAIT_STATES
//                wait cycles for RAM accesses while holding the pipeline with
//                stall, then completes with a one-cycle resp_valid pulse.
//                The word at IO_ADDR is memory-mapped I/O: stores update the
//                LED register, loads return the SW inputs. Any other address
//                outside the implemented RAM is unmapped: stores are dropped,
//                loads return zero with resp_err.
//
//  Ports       :
//    clk         in   1           rising-edge clock
//    nReset      in   1           synchronous active-low reset
//    req_valid   in   1           request present (held while stall=1)
//    req_we      in   1           1 = store, 0 = load
//    req_addr    in   32          word address (low ADDR_WIDTH bits index RAM)
//    req_wdata   in   DATA_WIDTH  store data
//    SW          in   DATA_WIDTH  switch inputs, read at IO_ADDR
//    stall       out  1           pipeline freeze request (combinational)
//    resp_valid  out  1           one-cycle completion pulse
//    resp_rdata  out  DATA_WIDTH  load result, holds until the next load
//    resp_err    out  1           load completed to an unmapped address
//    LED         out  DATA_WIDTH  LED register, written at IO_ADDR
//
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          MEM_SIZE    = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] SW,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] LED
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [3:0]  c_wait_init = 4'(WAIT_STATES);
    localparam logic        c_has_wait  = (WAIT_STATES > 0);
    localparam logic [31:0] c_mem_size  = 32'(MEM_SIZE);

    // ------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_mem [0:MEM_SIZE-1];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_upper_zero;
    logic                  w_in_range;
    logic                  w_is_io;
    logic                  w_is_ram;

    assign w_index      = req_addr[ADDR_WIDTH-1:0];
    assign w_upper_zero = (req_addr[31:ADDR_WIDTH] == '0);
    assign w_in_range   = ({{(32-ADDR_WIDTH){1'b0}}, w_index} < c_mem_size);
    assign w_is_io      = (req_addr == IO_ADDR);
    assign w_is_ram     = !w_is_io && w_upper_zero && w_in_range;

    // ------------------------------------------------------------------
    // Completion qualifier: true on the edge that moves the FSM into ACK.
    // From IDLE this happens at once for I/O, unmapped addresses, or when
    // no wait states are configured; from WAIT it happens on the last
    // counted cycle provided the initiator is still presenting the request.
    // ------------------------------------------------------------------
    logic w_goto_ack;
    logic w_commit;

    assign w_goto_ack = req_valid &&
                        (((r_state == S_IDLE) && !(w_is_ram && c_has_wait)) ||
                         ((r_state == S_WAIT) && (r_wait_cnt == 4'd1)));

    // Reset wins over a completion on the same edge, so an access aborted
    // by reset never reaches the RAM array (which itself is not reset).
    assign w_commit = nReset && w_goto_ack;

    // The initiator is released during ACK; it may then advance its request.
    assign stall = req_valid && (r_state != S_ACK);

    // ------------------------------------------------------------------
    // Control FSM and registered response / LED
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            LED        <= '0;
        end else begin
            // Response flags are single-cycle: only asserted for ACK.
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_is_ram && c_has_wait) begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= c_wait_init;
                        end else begin
                            r_state <= S_ACK;
                        end
                    end
                end

                S_WAIT: begin
                    if (!req_valid) begin
                        // Request withdrawn (pipeline flush): drop it silently.
                        r_state    <= S_IDLE;
                        r_wait_cnt <= 4'd0;
                    end else if (r_wait_cnt == 4'd1) begin
                        r_state    <= S_ACK;
                        r_wait_cnt <= 4'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end

                // ACK is the completion cycle of the request still on the
                // bus, so req_valid is not examined here.
                S_ACK: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= 4'd0;
                end
            endcase

            if (w_goto_ack) begin
                resp_valid <= 1'b1;
                if (w_is_io) begin
                    if (req_we) begin
                        LED <= req_wdata;
                    end else begin
                        resp_rdata <= SW;
                    end
                end else if (w_is_ram) begin
                    if (!req_we) begin
                        resp_rdata <= r_mem[w_index];
                    end
                end else begin
                    // Unmapped: stores vanish, loads report an error.
                    if (!req_we) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM write port (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_commit && req_we && w_is_ram) begin
            r_mem[w_index] <= req_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. Two instances
//                share the clock and reset: one with two wait states and one
//                with none. A select line routes each request to one of them.
//                Expected results come from a word-array model of RAM, LED
//                and the last load result.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int          DW = 32;
    localparam logic [31:0] IO = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          nReset;
    logic          req_valid;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] SW;
    logic          sel;

    logic          valid_a, valid_b;
    logic          stall_a, stall_b, rv_a, rv_b, err_a, err_b;
    logic [DW-1:0] rd_a, rd_b, led_a, led_b;
    logic          stall_m, rv_m, err_m;
    logic [DW-1:0] rd_m, led_m;

    assign valid_a = req_valid && !sel;
    assign valid_b = req_valid && sel;
    assign stall_m = sel ? stall_b : stall_a;
    assign rv_m    = sel ? rv_b    : rv_a;
    assign err_m   = sel ? err_b   : err_a;
    assign rd_m    = sel ? rd_b    : rd_a;
    assign led_m   = sel ? led_b   : led_a;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(10), .MEM_SIZE(1024),
                         .WAIT_STATES(2), .IO_ADDR(IO)) dut_a (
        .clk(clk), .nReset(nReset), .req_valid(valid_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .SW(SW),
        .stall(stall_a), .resp_valid(rv_a), .resp_rdata(rd_a),
        .resp_err(err_a), .LED(led_a));

    data_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(10), .MEM_SIZE(1024),
                         .WAIT_STATES(0), .IO_ADDR(IO)) dut_b (
        .clk(clk), .nReset(nReset), .req_valid(valid_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .SW(SW),
        .stall(stall_b), .resp_valid(rv_b), .resp_rdata(rd_b),
        .resp_err(err_b), .LED(led_b));

    // ------------------------------------------------------------------
    // Reference model: per instance RAM words, written flags, LED, last load
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [2][1024];
    bit            m_wr  [2][1024];
    logic [DW-1:0] m_led [2];
    logic [DW-1:0] m_rd  [2];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int last_ack;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called just after a rising edge. Presents one request to the selected
    // instance, counts stall cycles up to the completion and checks it.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [DW-1:0] wd, input bit release_after);
        int  s, ws, exp_stalls, stalls;
        bit  is_io, is_ram;
        logic exp_err;
        s      = sel ? 1 : 0;
        ws     = sel ? 0 : 2;
        is_io  = (addr == IO);
        is_ram = !is_io && (addr < 32'd1024);
        exp_stalls = (is_ram && ws > 0) ? ws + 1 : 1;
        exp_err = 1'b0;
        if (we) begin
            if (is_io) m_led[s] = wd;
            else if (is_ram) begin
                m_mem[s][addr[9:0]] = wd;
                m_wr[s][addr[9:0]]  = 1'b1;
            end
        end else begin
            if (is_io)       m_rd[s] = SW;
            else if (is_ram) m_rd[s] = m_mem[s][addr[9:0]];
            else begin
                m_rd[s] = '0;
                exp_err = 1'b1;
            end
        end

        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        stalls = 0;
        while (stall_m === 1'b1 && stalls < 40) begin
            chk("resp_valid_low_while_stalled", 32'(rv_m), 32'd0);
            stalls++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("resp_valid_in_ack", 32'(rv_m), 32'd1);
        chk("resp_err", 32'(err_m), 32'(exp_err));
        chk("resp_rdata", rd_m, m_rd[s]);
        chk("LED", led_m, m_led[s]);
        last_ack = cyc;
        @(posedge clk);
        #1;
        if (release_after) req_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_stall"}, 32'(stall_m), 32'd0);
        chk({tag, "_resp_valid"}, 32'(rv_m), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t1;
        logic [31:0] a;
        logic        w;

        nReset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; SW = '0; sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_led[i] = '0;
            m_rd[i]  = '0;
            for (int j = 0; j < 1024; j++) m_wr[i][j] = 1'b0;
        end

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall_a", 32'(stall_a), 32'd0);
        chk("rst_rv_a", 32'(rv_a), 32'd0);
        chk("rst_rdata_a", rd_a, 32'd0);
        chk("rst_led_a", led_a, 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_rv_b", 32'(rv_b), 32'd0);
        chk("rst_rdata_b", rd_b, 32'd0);
        chk("rst_led_b", led_b, 32'd0);
        @(posedge clk);
        #1;
        nReset = 1'b1;
        check_idle("idle_after_reset");

        // RAM store / load with two wait states
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
        check_idle("after_store");
        access(1'b0, 32'h10, '0, 1'b1);

        // Memory-mapped I/O
        access(1'b1, IO, 32'h0000_00A5, 1'b1);
        SW = 32'h0000_003C;
        access(1'b0, IO, '0, 1'b1);

        // Unmapped load and store; index 0 must be untouched by the store
        access(1'b0, 32'h0000_1000, '0, 1'b1);
        access(1'b1, 32'h0, 32'h1111_1111, 1'b1);
        access(1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 1'b1);
        access(1'b0, 32'h0, '0, 1'b1);

        // Flush: request withdrawn in the first wait cycle
        access(1'b1, 32'h20, 32'hCAFE_F00D, 1'b1);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) check_idle("flush");
        access(1'b0, 32'h20, '0, 1'b1);

        // Reset on what would have been the completion edge
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        nReset = 1'b0;
        @(posedge clk);
        #1;
        nReset = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_led[i] = '0;
            m_rd[i]  = '0;
        end
        @(negedge clk);
        chk("rst_abort_rv", 32'(rv_a), 32'd0);
        chk("rst_abort_led", led_a, 32'd0);
        chk("rst_abort_rdata", rd_a, 32'd0);
        @(posedge clk);
        #1;
        check_idle("after_rst_abort");
        access(1'b0, 32'h20, '0, 1'b1);

        // Zero-wait instance: back-to-back loads
        sel = 1'b1;
        access(1'b1, 32'h4, 32'hA1A1_A1A1, 1'b1);
        access(1'b1, 32'h8, 32'hB2B2_B2B2, 1'b1);
        access(1'b0, 32'h4, '0, 1'b0);
        t1 = last_ack;
        access(1'b0, 32'h8, '0, 1'b1);
        chk("b2b_resp_spacing", 32'(last_ack - t1), 32'd2);

        // Randomized traffic on both instances
        for (int n = 0; n < 60; n++) begin
            int r;
            sel = (n >= 35);
            SW  = $urandom;
            r   = $urandom_range(0, 9);
            w   = 1'($urandom_range(0, 1));
            if (r < 6)      a = 32'($urandom_range(0, 63));
            else if (r < 8) a = IO;
            else            a = $urandom | 32'h0000_0400;
            if (!w && a < 32'd1024 && !m_wr[sel ? 1 : 0][a[9:0]]) w = 1'b1;
            access(w, a, $urandom, ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                check_idle("rand_gap");
            end
        end
        req_valid = 1'b0;
        check_idle("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "bench timed out");
    end

endmodule
`default_nettype wire
